// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder: FSM states and half-adder result.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic s;
    logic c;
  } ha_t;

  function automatic ha_t ha_eval(input logic a, input logic b);
    ha_t r;
    r.s = a ^ b;
    r.c = a & b;
    return r;
  endfunction

endpackage

// File: rtl/ha_cell.sv
// One-bit half adder; two of these plus a carry register form the serial full adder.
module ha_cell
  import serial_add_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  output ha_t  r_o
);

  assign r_o = ha_eval(a_i, b_i);

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial W-bit adder, LSB first, start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder_seq
  import serial_add_pkg::*;
#(
  parameter  int W     = 8,
  localparam int CNT_W = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  state_e           state_q;
  logic [W-1:0]     a_sh_q;
  logic [W-1:0]     b_sh_q;
  logic [W-1:0]     res_sh_q;
  logic [W-1:0]     sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             c_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  ha_t  ha0;
  ha_t  ha1;
  logic bit_s;
  logic c_next;
  logic last;

  ha_cell u_ha0 (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .r_o (ha0)
  );

  ha_cell u_ha1 (
    .a_i (ha0.s),
    .b_i (c_q),
    .r_o (ha1)
  );

  assign bit_s  = ha1.s;
  assign c_next = ha0.c | ha1.c;
  assign last   = (cnt_q == LAST);

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // Carry into the MSB is c_q on the last bit; xor with carry out flags overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == SHIFT && last) begin
      ovf_q <= c_q ^ c_next;
    end
  end

  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a_in;
            b_sh_q  <= b_in;
            c_q     <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          res_sh_q <= {bit_s, res_sh_q[W-1:1]};
          c_q      <= c_next;
          cnt_q    <= cnt_q + 1'b1;
          if (last) begin
            sum_q   <= {bit_s, res_sh_q[W-1:1]};
            cout_q  <= c_next;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
